math_operand_collector: RTL and testbench

//   Upstream feeder for the math computer. Takes a serial stream of operand

---
 rtl/math_operand_collector.sv | 108 ++++++++++
 tb/tb_math_operand_collector.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/math_operand_collector.sv
// rtl/math_operand_collector.sv - groups a serial operand stream into (a, b, c) triplets
// Collection stage (reg_a/reg_b) is decoupled from the output register so gathering overlaps the hand-off.
module math_operand_collector #(
  parameter int DATASIZE = 16,
  parameter int CNTSIZE  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATASIZE-1:0] in_data,
  input  logic                in_clear,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATASIZE-1:0] out_a,
  output logic [DATASIZE-1:0] out_b,
  output logic [DATASIZE-1:0] out_c,
  output logic [1:0]          idx,
  output logic [CNTSIZE-1:0]  triplet_cnt
);

  logic [1:0]          idx_q, idx_d;
  logic [DATASIZE-1:0] reg_a_q, reg_a_d;
  logic [DATASIZE-1:0] reg_b_q, reg_b_d;
  logic [DATASIZE-1:0] out_a_q, out_a_d;
  logic [DATASIZE-1:0] out_b_q, out_b_d;
  logic [DATASIZE-1:0] out_c_q, out_c_d;
  logic                out_valid_q, out_valid_d;
  logic [CNTSIZE-1:0]  cnt_q, cnt_d;

  logic accept;
  logic load;
  logic handshake;

  // The third word may only enter when the output slot is free or draining this cycle.
  assign in_ready  = rst && !in_clear && ((idx_q != 2'd2) || !out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign load      = accept && (idx_q == 2'd2);
  assign handshake = out_valid_q && out_ready;

  always_comb begin
    idx_d       = idx_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;

    if (handshake) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + {{(CNTSIZE-1){1'b0}}, 1'b1};
    end

    if (in_clear) begin
      idx_d = 2'd0;
    end else if (accept) begin
      case (idx_q)
        2'd0: begin
          reg_a_d = in_data;
          idx_d   = 2'd1;
        end
        2'd1: begin
          reg_b_d = in_data;
          idx_d   = 2'd2;
        end
        default: begin
          out_a_d     = reg_a_q;
          out_b_d     = reg_b_q;
          out_c_d     = in_data;
          out_valid_d = 1'b1;
          idx_d       = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= 2'd0;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      idx_q       <= idx_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_c       = out_c_q;
  assign idx         = idx_q;
  assign triplet_cnt = cnt_q;

endmodule

// File: tb/tb_math_operand_collector.sv
// tb/tb_math_operand_collector.sv - scoreboard bench for math_operand_collector
// A cycle-level reference of the handshake rules predicts readiness and pushes expected triplets.
module tb_math_operand_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_clear;
  logic        out_ready;
  logic        in_ready, in_ready2;
  logic        out_valid, out_valid2;
  logic [15:0] out_a, out_b, out_c, out_a2, out_b2, out_c2;
  logic [1:0]  idx, idx2;
  logic [15:0] triplet_cnt;
  logic [1:0]  triplet_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  logic [47:0] sb[$];
  logic [1:0]  m_idx;
  logic [15:0] m_a, m_b;
  logic        m_ov;
  int          m_cnt;

  always #5 clk = ~clk;

  math_operand_collector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_clear(in_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .idx(idx), .triplet_cnt(triplet_cnt)
  );

  math_operand_collector #(.DATASIZE(16), .CNTSIZE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_clear(in_clear), .out_valid(out_valid2), .out_ready(out_ready),
    .out_a(out_a2), .out_b(out_b2), .out_c(out_c2), .idx(idx2), .triplet_cnt(triplet_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 2'd0;
    m_a   = '0;
    m_b   = '0;
    m_ov  = 1'b0;
    m_cnt = 0;
    sb.delete();
  endtask

  // One clock: drive after the falling edge, check just before the rising edge, advance the model.
  task automatic cyc(input logic v, input logic [15:0] d, input logic clr, input logic ordy,
                     output logic acc);
    logic exp_rdy;
    in_valid  = v;
    in_data   = d;
    in_clear  = clr;
    out_ready = ordy;
    #1;
    exp_rdy = !clr && ((m_idx != 2'd2) || !m_ov || ordy);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_ov);
    check("idx", idx, m_idx);
    check("triplet_cnt", triplet_cnt, m_cnt[15:0]);
    check("triplet_cnt_w2", triplet_cnt2, m_cnt[1:0]);
    if (out_valid) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        check("out_abc", {out_a, out_b, out_c}, sb[0]);
        check("out_abc_w2", {out_a2, out_b2, out_c2}, sb[0]);
        if (ordy) void'(sb.pop_front());
      end
    end
    acc = v && exp_rdy;
    if (m_ov && ordy) begin
      m_ov = 1'b0;
      m_cnt++;
    end
    if (clr) m_idx = 2'd0;
    else if (acc) begin
      case (m_idx)
        2'd0: begin m_a = d; m_idx = 2'd1; end
        2'd1: begin m_b = d; m_idx = 2'd2; end
        default: begin sb.push_back({m_a, m_b, d}); m_ov = 1'b1; m_idx = 2'd0; end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d, input logic ordy);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      cyc(1'b1, d, 1'b0, ordy, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, ordy, acc);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_idx", idx, 0);
    check("rst_cnt", triplet_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_abc", {out_a, out_b, out_c}, 48'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic acc;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_clear = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check("init_out_valid", out_valid, 0);
    check("init_idx", idx, 0);
    check("init_cnt", triplet_cnt, 0);
    check("init_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;

    // single triplet, latency one cycle
    send(16'd1, 1'b1); send(16'd2, 1'b1); send(16'd3, 1'b1);
    check("t1_latency", out_valid, 1);
    idle(1, 1'b1);
    check("t1_cnt", triplet_cnt, 1);

    // back-to-back stream, no bubble
    for (int i = 1; i <= 9; i++) cyc(1'b1, 16'(i), 1'b0, 1'b1, acc);
    idle(2, 1'b1);
    check("t2_cnt", triplet_cnt, 4);
    check("t2_sb_empty", sb.size(), 0);

    // backpressure: sixth word stalls until the output drains
    for (int i = 1; i <= 5; i++) send(16'(i), 1'b0);
    cyc(1'b1, 16'd6, 1'b0, 1'b0, acc);
    check("t3_stall", acc, 0);
    cyc(1'b1, 16'd6, 1'b0, 1'b1, acc);
    check("t3_accept", acc, 1);
    idle(3, 1'b1);
    check("t3_sb_empty", sb.size(), 0);

    // clear discards the partial triplet
    send(16'd10, 1'b1); send(16'd20, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, acc);
    send(16'd7, 1'b1); send(16'd8, 1'b1); send(16'd9, 1'b1);
    idle(2, 1'b1);
    check("t4_sb_empty", sb.size(), 0);

    // clear with a pending output: hand-off still completes
    send(16'd11, 1'b0); send(16'd12, 1'b0); send(16'd13, 1'b0); send(16'd14, 1'b0);
    cyc(1'b1, 16'd15, 1'b1, 1'b1, acc);
    idle(2, 1'b1);

    // async reset mid-triplet, then with out_valid set
    send(16'd21, 1'b1);
    async_reset();
    send(16'd31, 1'b0); send(16'd32, 1'b0); send(16'd33, 1'b0);
    check("t5_ov_before_rst", out_valid, 1);
    async_reset();
    send(16'd41, 1'b1); send(16'd42, 1'b1); send(16'd43, 1'b1);
    idle(2, 1'b1);
    check("t5_cnt_after", triplet_cnt, 1);

    // counter wrap on the narrow instance, all-ones data
    async_reset();
    for (int t = 0; t < 5; t++) begin
      send(16'hFFFF, 1'b1); send(16'hFFFF, 1'b1); send(16'hFFFF, 1'b1);
    end
    idle(2, 1'b1);
    check("t6_cnt_w2_wrap", triplet_cnt2, 1);
    check("t6_cnt", triplet_cnt, 5);

    // random traffic with random backpressure and clears
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 2) != 0), acc);
    idle(6, 1'b1);
    check("rand_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
